// File: rtl/dispatch_queue.sv
// Circular dispatch queue between decode and the ROB/RS: compacting N_WAY-wide enqueue, in-order prefix dequeue.
// Optional statistics outputs (stall_cycles, max_count) are enabled by defining DISPATCH_QUEUE_STATS_EN.
module dispatch_queue #(
  parameter int N_WAY = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [N_WAY-1:0]             in_valid,
  input  logic [N_WAY*XLEN-1:0]        in_pc,
  input  logic [N_WAY*XLEN-1:0]        in_npc,
  input  logic [N_WAY*32-1:0]          in_inst,
  input  logic [N_WAY*5-1:0]           in_src1,
  input  logic [N_WAY*5-1:0]           in_src2,
  input  logic [N_WAY*5-1:0]           in_dest,
  output logic                         in_ready,
  output logic [N_WAY-1:0]             out_valid,
  output logic [N_WAY*XLEN-1:0]        out_pc,
  output logic [N_WAY*XLEN-1:0]        out_npc,
  output logic [N_WAY*32-1:0]          out_inst,
  output logic [N_WAY*5-1:0]           out_src1,
  output logic [N_WAY*5-1:0]           out_src2,
  output logic [N_WAY*5-1:0]           out_dest,
  input  logic [N_WAY-1:0]             dispatched,
  output logic [$clog2(DEPTH):0]       count
`ifdef DISPATCH_QUEUE_STATS_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [$clog2(DEPTH):0]       max_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] npc_mem  [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [4:0]      src1_mem [DEPTH];
  logic [4:0]      src2_mem [DEPTH];
  logic [4:0]      dest_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_next;
  logic [CW-1:0] enq_cnt;
  logic [CW-1:0] deq_cnt;
  logic [PW-1:0] enq_off [N_WAY];
  logic          deq_run;

  assign in_ready = (CW'(DEPTH) - count) >= CW'(N_WAY);

  // Valid lanes are packed: each lane's slot offset is the number of valid lanes below it.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < N_WAY; i++) begin
      enq_off[i] = enq_cnt[PW-1:0];
      if (in_valid[i]) enq_cnt = enq_cnt + CW'(1);
    end
    if (!in_ready) enq_cnt = '0;
  end

  // Retire only the leading run of accepted lanes so entries leave strictly in order.
  always_comb begin
    deq_cnt = '0;
    deq_run = 1'b1;
    for (int i = 0; i < N_WAY; i++) begin
      if (deq_run && dispatched[i] && out_valid[i]) deq_cnt = deq_cnt + CW'(1);
      else deq_run = 1'b0;
    end
  end

  always_comb begin
    count_next = flush ? '0 : (count + enq_cnt - deq_cnt);
  end

  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_npc   = '0;
    out_inst  = '0;
    out_src1  = '0;
    out_src2  = '0;
    out_dest  = '0;
    for (int i = 0; i < N_WAY; i++) begin
      out_valid[i]              = CW'(i) < count;
      out_pc[i*XLEN +: XLEN]    = pc_mem[head + PW'(i)];
      out_npc[i*XLEN +: XLEN]   = npc_mem[head + PW'(i)];
      out_inst[i*32 +: 32]      = inst_mem[head + PW'(i)];
      out_src1[i*5 +: 5]        = src1_mem[head + PW'(i)];
      out_src2[i*5 +: 5]        = src2_mem[head + PW'(i)];
      out_dest[i*5 +: 5]        = dest_mem[head + PW'(i)];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + deq_cnt[PW-1:0];
      tail  <= tail + enq_cnt[PW-1:0];
      count <= count_next;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (in_ready && in_valid[i] && !flush) begin
        pc_mem[tail + enq_off[i]]   <= in_pc[i*XLEN +: XLEN];
        npc_mem[tail + enq_off[i]]  <= in_npc[i*XLEN +: XLEN];
        inst_mem[tail + enq_off[i]] <= in_inst[i*32 +: 32];
        src1_mem[tail + enq_off[i]] <= in_src1[i*5 +: 5];
        src2_mem[tail + enq_off[i]] <= in_src2[i*5 +: 5];
        dest_mem[tail + enq_off[i]] <= in_dest[i*5 +: 5];
      end
    end
  end

`ifdef DISPATCH_QUEUE_STATS_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      max_count    <= '0;
    end else begin
      if (|in_valid && !in_ready && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (count_next > max_count)
        max_count <= count_next;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_dispatch_queue;

  localparam int N_WAY = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  flush = 1'b0;
  logic [N_WAY-1:0]      in_valid = '0;
  logic [N_WAY*XLEN-1:0] in_pc = '0, in_npc = '0;
  logic [N_WAY*32-1:0]   in_inst = '0;
  logic [N_WAY*5-1:0]    in_src1 = '0, in_src2 = '0, in_dest = '0;
  logic                  in_ready;
  logic [N_WAY-1:0]      out_valid;
  logic [N_WAY*XLEN-1:0] out_pc, out_npc;
  logic [N_WAY*32-1:0]   out_inst;
  logic [N_WAY*5-1:0]    out_src1, out_src2, out_dest;
  logic [N_WAY-1:0]      dispatched = '0;
  logic [3:0]            count;
`ifdef DISPATCH_QUEUE_STATS_EN
  logic [31:0]           stall_cycles;
  logic [3:0]            max_count;
`endif

  dispatch_queue #(.N_WAY(N_WAY), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_npc(in_npc), .in_inst(in_inst),
    .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_npc(out_npc), .out_inst(out_inst),
    .out_src1(out_src1), .out_src2(out_src2), .out_dest(out_dest),
    .dispatched(dispatched), .count(count)
`ifdef DISPATCH_QUEUE_STATS_EN
    , .stall_cycles(stall_cycles), .max_count(max_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] inst;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
  } ent_t;

  ent_t mq[$];
  int   m_stall = 0;
  int   m_max   = 0;
  int   checks  = 0;
  int   errors  = 0;

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = '0; dispatched = '0;
    mq.delete(); m_stall = 0; m_max = 0;
    @(posedge clock); @(posedge clock); @(negedge clock);
    reset = 1'b0;
  endtask

  // Applies one cycle of stimulus to the DUT and advances the reference queue by the same rules.
  task automatic drive(input logic [1:0] iv, input logic [1:0] disp, input logic fl,
                       input logic [31:0] pc0, input logic [31:0] pc1);
    ent_t e [2];
    bit   rdy;
    int   k;
    for (int i = 0; i < 2; i++) begin
      e[i].pc   = (i == 0) ? pc0 : pc1;
      e[i].npc  = e[i].pc + 32'd4;
      e[i].inst = $urandom;
      e[i].s1   = 5'($urandom_range(0, 31));
      e[i].s2   = 5'($urandom_range(0, 31));
      e[i].d    = 5'($urandom_range(0, 31));
      in_pc[i*32 +: 32]   = e[i].pc;
      in_npc[i*32 +: 32]  = e[i].npc;
      in_inst[i*32 +: 32] = e[i].inst;
      in_src1[i*5 +: 5]   = e[i].s1;
      in_src2[i*5 +: 5]   = e[i].s2;
      in_dest[i*5 +: 5]   = e[i].d;
    end
    in_valid = iv; dispatched = disp; flush = fl;
    rdy = (DEPTH - mq.size()) >= N_WAY;
    if (iv != 2'b00 && !rdy) m_stall++;
    if (fl) mq.delete();
    else begin
      k = 0;
      for (int i = 0; i < 2; i++) begin
        if (disp[i] && i < mq.size() && k == i) k++;
      end
      repeat (k) void'(mq.pop_front());
      if (rdy) for (int i = 0; i < 2; i++) if (iv[i]) mq.push_back(e[i]);
    end
    if (mq.size() > m_max) m_max = mq.size();
    @(posedge clock); @(negedge clock);
    in_valid = '0; dispatched = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got %b exp 00", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    drive(2'b11, 2'b00, 1'b0, 32'h10, 32'h14);
    drive(2'b11, 2'b00, 1'b0, 32'h18, 32'h1c);
    reset = 1'b1; in_valid = 2'b11; dispatched = 2'b11;
    @(posedge clock); @(negedge clock);
    reset = 1'b0; in_valid = '0; dispatched = '0;
    mq.delete(); m_stall = 0; m_max = 0;
    checks++; if (count !== 4'd0 || out_valid !== 2'b00) begin
      errors++; $display("FAIL midop_reset count %0d valid %b exp 0/00", count, out_valid); end
`ifdef DISPATCH_QUEUE_STATS_EN
    checks++; if (stall_cycles !== 32'd0 || max_count !== 4'd0) begin
      errors++; $display("FAIL midop_reset_stats got %0d/%0d exp 0/0", stall_cycles, max_count); end
`endif
  endtask

  task automatic test_basic();
    do_reset();
    drive(2'b11, 2'b00, 1'b0, 32'h0, 32'h4);
    checks++; if (count !== 4'd2 || out_valid !== 2'b11) begin
      errors++; $display("FAIL basic_count got %0d/%b exp 2/11", count, out_valid); end
    checks++; if (out_pc[31:0] !== 32'h0 || out_pc[63:32] !== 32'h4) begin
      errors++; $display("FAIL basic_pc got %h/%h exp 0/4", out_pc[31:0], out_pc[63:32]); end
  endtask

  task automatic test_partial_dispatch();
    do_reset();
    drive(2'b11, 2'b00, 1'b0, 32'h0, 32'h4);
    drive(2'b01, 2'b00, 1'b0, 32'h8, 32'h0);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL partial_fill got %0d exp 3", count); end
    drive(2'b00, 2'b01, 1'b0, 32'h0, 32'h0);
    checks++; if (count !== 4'd2 || out_pc[31:0] !== 32'h4 || out_pc[63:32] !== 32'h8) begin
      errors++; $display("FAIL partial_deq got %0d %h %h exp 2 4 8", count, out_pc[31:0], out_pc[63:32]); end
    drive(2'b00, 2'b10, 1'b0, 32'h0, 32'h0);
    checks++; if (count !== 4'd2 || out_pc[31:0] !== 32'h4) begin
      errors++; $display("FAIL nonprefix_deq got %0d %h exp 2 4", count, out_pc[31:0]); end
  endtask

  task automatic test_compaction();
    do_reset();
    drive(2'b10, 2'b00, 1'b0, 32'h99, 32'h40);
    checks++; if (out_valid !== 2'b01 || out_pc[31:0] !== 32'h40 || count !== 4'd1) begin
      errors++; $display("FAIL compaction got %b %h %0d exp 01 40 1", out_valid, out_pc[31:0], count); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int n = 0; n < 3; n++) drive(2'b11, 2'b00, 1'b0, 32'(8*n), 32'(8*n+4));
    checks++; if (count !== 4'd6 || in_ready !== 1'b1) begin
      errors++; $display("FAIL fill6 got %0d/%b exp 6/1", count, in_ready); end
    drive(2'b11, 2'b00, 1'b0, 32'h18, 32'h1c);
    checks++; if (count !== 4'd8 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill8 got %0d/%b exp 8/0", count, in_ready); end
    drive(2'b11, 2'b00, 1'b0, 32'h100, 32'h104);
    checks++; if (count !== 4'd8 || out_pc[31:0] !== 32'h0) begin
      errors++; $display("FAIL full_ignore got %0d %h exp 8 0", count, out_pc[31:0]); end
    drive(2'b00, 2'b01, 1'b0, 32'h0, 32'h0);
    checks++; if (count !== 4'd7 || in_ready !== 1'b0 || out_pc[31:0] !== 32'h4) begin
      errors++; $display("FAIL count7 got %0d/%b %h exp 7/0 4", count, in_ready, out_pc[31:0]); end
    drive(2'b11, 2'b00, 1'b0, 32'h200, 32'h204);
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL count7_ignore got %0d exp 7", count); end
    do_reset();
    drive(2'b11, 2'b00, 1'b0, 32'h0, 32'h4);
    for (int j = 1; j <= 20; j++) begin
      drive(2'b11, 2'b11, 1'b0, 32'(8*j), 32'(8*j+4));
      checks++;
      if (count !== 4'd2 || out_pc[31:0] !== 32'(8*j) || out_pc[63:32] !== 32'(8*j+4)) begin
        errors++; $display("FAIL wrap_%0d got %0d %h %h exp 2 %h %h", j, count, out_pc[31:0], out_pc[63:32], 8*j, 8*j+4);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(2'b11, 2'b00, 1'b0, 32'h0, 32'h4);
    drive(2'b11, 2'b00, 1'b0, 32'h8, 32'hc);
    drive(2'b01, 2'b00, 1'b0, 32'h10, 32'h0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre got %0d exp 5", count); end
    drive(2'b11, 2'b11, 1'b1, 32'h20, 32'h24);
    checks++; if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush got %0d %b %b exp 0 00 1", count, out_valid, in_ready); end
`ifdef DISPATCH_QUEUE_STATS_EN
    checks++; if (stall_cycles !== 32'd0 || max_count !== 4'd5) begin
      errors++; $display("FAIL flush_stats got %0d/%0d exp 0/5", stall_cycles, max_count); end
`endif
  endtask

  task automatic test_stats();
`ifdef DISPATCH_QUEUE_STATS_EN
    do_reset();
    for (int n = 0; n < 4; n++) drive(2'b11, 2'b00, 1'b0, 32'(8*n), 32'(8*n+4));
    for (int n = 0; n < 4; n++) drive(2'b01, 2'b00, 1'b0, 32'h300, 32'h0);
    checks++; if (stall_cycles !== 32'd4 || max_count !== 4'd8) begin
      errors++; $display("FAIL stats got %0d/%0d exp 4/8", stall_cycles, max_count); end
    do_reset();
    checks++; if (stall_cycles !== 32'd0 || max_count !== 4'd0) begin
      errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", stall_cycles, max_count); end
`endif
  endtask

  task automatic test_random();
    ent_t e;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom), 2'($urandom), ($urandom_range(0, 24) == 0), $urandom, $urandom);
      checks++;
      if (count !== 4'(mq.size()) || in_ready !== ((DEPTH - mq.size()) >= N_WAY)) begin
        errors++; $display("FAIL rand_count@%0d got %0d/%b exp %0d", n, count, in_ready, mq.size());
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (out_valid[i] !== (i < mq.size())) begin
          errors++; $display("FAIL rand_valid@%0d lane%0d got %b", n, i, out_valid[i]);
        end else if (i < mq.size()) begin
          e = mq[i];
          if ({out_pc[i*32 +: 32], out_npc[i*32 +: 32], out_inst[i*32 +: 32],
               out_src1[i*5 +: 5], out_src2[i*5 +: 5], out_dest[i*5 +: 5]} !==
              {e.pc, e.npc, e.inst, e.s1, e.s2, e.d}) begin
            errors++; $display("FAIL rand_fields@%0d lane%0d got pc %h inst %h exp pc %h inst %h",
                               n, i, out_pc[i*32 +: 32], out_inst[i*32 +: 32], e.pc, e.inst);
          end
        end
      end
`ifdef DISPATCH_QUEUE_STATS_EN
      checks++;
      if (stall_cycles !== 32'(m_stall) || max_count !== 4'(m_max)) begin
        errors++; $display("FAIL rand_stats@%0d got %0d/%0d exp %0d/%0d", n, stall_cycles, max_count, m_stall, m_max);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_dispatch();
    test_compaction();
    test_full_wrap();
    test_flush();
    test_stats();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
